// File: rtl/fetch_seq_if.sv
// fetch_seq_if: instruction-memory, redirect and decode-side signals of the
// fetch sequencer. The master modport is the sequencer; the slave modport is
// its environment (memory, branch unit and decode).
interface fetch_seq_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_exc;
  logic        d_ready;

  modport master (
    output im_req, im_addr, f_valid, f_instr, f_pc, f_exc,
    input  im_ack, im_rdata, redir_valid, redir_pc, d_ready
  );

  modport slave (
    input  im_req, im_addr, f_valid, f_instr, f_pc, f_exc,
    output im_ack, im_rdata, redir_valid, redir_pc, d_ready
  );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch sequencer with a 2-entry output buffer.
// A request is only issued when a buffer slot is guaranteed free at ack time,
// so the buffer never overflows. Redirects flush the buffer; an ack still
// outstanding at redirect time is absorbed in DROP and its data discarded.
// Optional feature macro: FETCH_ALIGN_CHK_EN (misaligned redirect pushes an
// address-error marker and halts fetching until the next aligned redirect).
module fetch_seq (
  input  logic        clk,
  input  logic        reset,
  fetch_seq_if.master bus
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_REQ   = 2'd1;
  localparam logic [1:0]  ST_DROP  = 2'd2;
  localparam logic [31:0] RST_PC   = 32'h0000_3004;
  localparam logic [31:0] RST_REQ  = 32'h0000_3000;

  // Buffer entry layout: [64:33] instruction, [32:1] address, [0] exc marker.
  function automatic logic [64:0] make_ent(input logic [31:0] instr,
                                           input logic [31:0] addr,
                                           input logic        exc);
    make_ent = {instr, addr, exc};
  endfunction

  // Sequential address, modulo 2^32.
  function automatic logic [31:0] next_addr(input logic [31:0] addr);
    next_addr = addr + 32'd4;
  endfunction

  logic [1:0]  state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] req_addr, req_addr_nx;
  logic [1:0]  count, count_nx;
  logic [64:0] ent0, ent0_nx;
  logic [64:0] ent1, ent1_nx;
  logic        halted, halted_nx;
  logic        req_on;

  logic        pop;
  logic [1:0]  cnt_after_pop;
  logic        push;
  logic [64:0] push_ent;
  logic        flush;
  logic [31:0] tgt;
  logic        misal;

`ifdef FETCH_ALIGN_CHK_EN
  assign tgt   = bus.redir_pc;
  assign misal = (bus.redir_pc[1:0] != 2'b00);
`else
  assign tgt   = bus.redir_pc & 32'hFFFF_FFFC;
  assign misal = 1'b0;
`endif

  assign pop           = (count != 2'd0) && bus.d_ready;
  assign cnt_after_pop = count - {1'b0, pop};

  // FSM, fetch address and push decision; redirect outranks every other event.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    req_addr_nx = req_addr;
    halted_nx   = halted;
    push        = 1'b0;
    push_ent    = 65'd0;
    flush       = 1'b0;
    if (bus.redir_valid) begin
      flush = 1'b1;
      pc_nx = tgt;
      if (misal) begin
        halted_nx = 1'b1;
        push      = 1'b1;
        push_ent  = make_ent(32'd0, tgt, 1'b1);
        case (state)
          ST_IDLE: state_nx = ST_IDLE;
          ST_REQ:  state_nx = bus.im_ack ? ST_IDLE : ST_DROP;
          ST_DROP: state_nx = bus.im_ack ? ST_IDLE : ST_DROP;
          default: state_nx = ST_IDLE;
        endcase
      end else begin
        halted_nx = 1'b0;
        case (state)
          ST_IDLE: begin
            state_nx    = ST_REQ;
            req_addr_nx = tgt;
          end
          ST_REQ, ST_DROP: begin
            if (bus.im_ack) begin
              state_nx    = ST_REQ;
              req_addr_nx = tgt;
            end else begin
              state_nx = ST_DROP;
            end
          end
          default: begin
            state_nx    = ST_REQ;
            req_addr_nx = tgt;
          end
        endcase
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (!halted && (cnt_after_pop <= 2'd1)) begin
            state_nx    = ST_REQ;
            req_addr_nx = pc;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus.im_ack) begin
            push     = 1'b1;
            push_ent = make_ent(bus.im_rdata, req_addr, 1'b0);
            pc_nx    = next_addr(req_addr);
            // After the push the count is at most 1 only if the buffer drained.
            if (cnt_after_pop == 2'd0) begin
              req_addr_nx = next_addr(req_addr);
            end else begin
              state_nx = ST_IDLE;
            end
          end else begin
            state_nx = ST_REQ;
          end
        end
        ST_DROP: begin
          if (bus.im_ack) begin
            if (halted) begin
              state_nx = ST_IDLE;
            end else begin
              state_nx    = ST_REQ;
              req_addr_nx = pc;
            end
          end else begin
            state_nx = ST_DROP;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Output buffer: flush, shift on pop, write push into first free slot.
  always_comb begin
    ent0_nx  = ent0;
    ent1_nx  = ent1;
    count_nx = count;
    if (flush) begin
      count_nx = {1'b0, push};
      if (push) begin
        ent0_nx = push_ent;
      end else begin
        ent0_nx = ent0;
      end
    end else begin
      if (pop) begin
        ent0_nx = ent1;
      end else begin
        ent0_nx = ent0;
      end
      if (push) begin
        if (cnt_after_pop == 2'd0) begin
          ent0_nx = push_ent;
        end else begin
          ent1_nx = push_ent;
        end
      end else begin
        ent1_nx = ent1;
      end
      count_nx = cnt_after_pop + {1'b0, push};
    end
  end

  // State registers with synchronous reset; a pending request is abandoned.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_REQ;
      pc       <= RST_PC;
      req_addr <= RST_REQ;
      count    <= 2'd0;
      ent0     <= 65'd0;
      ent1     <= 65'd0;
      halted   <= 1'b0;
      req_on   <= 1'b1;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      req_addr <= req_addr_nx;
      count    <= count_nx;
      ent0     <= ent0_nx;
      ent1     <= ent1_nx;
      halted   <= halted_nx;
      req_on   <= (state_nx != ST_IDLE);
    end
  end

  assign bus.im_req  = req_on;
  assign bus.im_addr = req_addr;
  assign bus.f_valid = (count != 2'd0) && !reset;
  assign bus.f_instr = bus.f_valid ? ent0[64:33] : 32'd0;
  assign bus.f_pc    = bus.f_valid ? ent0[32:1] : 32'd0;
`ifdef FETCH_ALIGN_CHK_EN
  assign bus.f_exc   = bus.f_valid & ent0[0];
`else
  logic unused_exc;
  assign unused_exc  = ent0[0];
  assign bus.f_exc   = 1'b0;
`endif

endmodule
